// File: rtl/skew_feeder_pkg.sv
// Shared types and sizing helpers for the skew_feeder block.
package skew_feeder_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    function automatic int unsigned num_steps(input int unsigned dim);
        return 2 * dim - 1;
    endfunction

    function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c,
                                             input int unsigned dim);
        return r * dim + c;
    endfunction

    // Width of a counter that spans 0 .. num_steps(dim)-1, never zero.
    function automatic int unsigned step_bits(input int unsigned dim);
        return (num_steps(dim) > 1) ? $clog2(num_steps(dim)) : 1;
    endfunction

endpackage

// File: rtl/skew_feeder_if.sv
// Upstream matrix handshake plus downstream skewed-lane beat handshake.
interface skew_feeder_if #(
    parameter int unsigned width_p = 8,
    parameter int unsigned dim_p   = 4
);
    logic                             valid_i;
    logic [width_p*dim_p*dim_p-1:0]   data_i;
    logic                             ready_o;
    logic                             valid_o;
    logic                             ready_i;
    logic [width_p*dim_p-1:0]         data_o;
    logic [dim_p-1:0]                 lane_valid_o;
    logic                             last_o;

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, lane_valid_o, last_o
    );

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, lane_valid_o, last_o
    );
endinterface

// File: rtl/skew_lane_sel.sv
// Picks the element a single row lane carries on a given step: row r shows column step-r.
module skew_lane_sel #(
    parameter int unsigned width_p = 8,
    parameter int unsigned dim_p   = 4,
    parameter int unsigned step_w  = 3,
    parameter int unsigned row_w   = 2
) (
    input  logic [row_w-1:0]         row,
    input  logic [step_w-1:0]        step,
    input  logic [width_p*dim_p-1:0] row_data,
    output logic [width_p-1:0]       elem_c,
    output logic                     valid_c
);
    localparam int unsigned CALC_W = ((step_w > row_w) ? step_w : row_w) + 1;

    logic [CALC_W-1:0] col;

    always_comb begin
        col     = CALC_W'(step) - CALC_W'(row);
        valid_c = (CALC_W'(step) >= CALC_W'(row)) && (col < CALC_W'(dim_p));
        elem_c  = '0;
        if (valid_c) begin
            elem_c = row_data[col*width_p +: width_p];
        end
    end
endmodule

// File: rtl/skew_feeder.sv
// Replays a captured dim_p x dim_p matrix as diagonally skewed west-edge lanes.
// Define SKEW_FEEDER_PINGPONG_EN to add a shadow buffer for back-to-back matrices.
module skew_feeder
    import skew_feeder_pkg::*;
#(
    parameter int unsigned width_p = 8,
    parameter int unsigned dim_p   = 4
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    skew_feeder_if.slave  bus
);
    localparam int unsigned MAT_W     = width_p * dim_p * dim_p;
    localparam int unsigned LANE_W    = width_p * dim_p;
    localparam int unsigned STEP_W    = step_bits(dim_p);
    localparam int unsigned ROW_W     = (dim_p > 1) ? $clog2(dim_p) : 1;
    localparam int unsigned LAST_STEP = num_steps(dim_p) - 1;

    logic [0:0]        state_r, state_n;
    logic [STEP_W-1:0] step_r, step_n;
    logic [MAT_W-1:0]  buf_r, buf_n;
    logic              valid_d_r;
    logic              ready_r, ready_n;
    logic              valid_r;
    logic [LANE_W-1:0] data_r;
    logic [dim_p-1:0]  lane_valid_r;
    logic              last_r;

    logic              accept_c, fire_c, final_c, stream_n;
    logic [LANE_W-1:0] lanes_c;
    logic [dim_p-1:0]  lane_valid_c;

`ifdef SKEW_FEEDER_PINGPONG_EN
    logic [MAT_W-1:0]  shd_r, shd_n;
    logic              shd_full_r, shd_full_n;
`endif

    // Next-state, step and buffer selection.
    always_comb begin
        state_n  = state_r;
        step_n   = step_r;
        buf_n    = buf_r;
`ifdef SKEW_FEEDER_PINGPONG_EN
        shd_n      = shd_r;
        shd_full_n = shd_full_r;
`endif
        accept_c = bus.valid_i & ~valid_d_r & ready_r;
        fire_c   = valid_r & bus.ready_i;
        final_c  = fire_c && (step_r == STEP_W'(LAST_STEP));

        case (state_r)
            IDLE: begin
`ifdef SKEW_FEEDER_PINGPONG_EN
                // A matrix parked while the previous one finished starts here.
                if (shd_full_r) begin
                    buf_n      = shd_r;
                    shd_full_n = 1'b0;
                    step_n     = '0;
                    state_n    = STREAM;
                end else
`endif
                if (accept_c) begin
                    buf_n   = bus.data_i;
                    step_n  = '0;
                    state_n = STREAM;
                end
            end
            STREAM: begin
                if (final_c) begin
                    step_n = '0;
`ifdef SKEW_FEEDER_PINGPONG_EN
                    if (shd_full_r) begin
                        buf_n      = shd_r;
                        shd_full_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
`else
                    state_n = IDLE;
`endif
                end else if (fire_c) begin
                    step_n = step_r + STEP_W'(1);
                end
`ifdef SKEW_FEEDER_PINGPONG_EN
                if (accept_c) begin
                    shd_n      = bus.data_i;
                    shd_full_n = 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase

        stream_n = (state_n == STREAM);
`ifdef SKEW_FEEDER_PINGPONG_EN
        ready_n = ~shd_full_n;
`else
        ready_n = (state_n == IDLE);
`endif
    end

    // Lane selection runs on next-state values so the beat outputs can be registered.
    for (genvar r = 0; r < dim_p; r++) begin : g_lane
        skew_lane_sel #(
            .width_p (width_p),
            .dim_p   (dim_p),
            .step_w  (STEP_W),
            .row_w   (ROW_W)
        ) u_lane_sel (
            .row      (ROW_W'(r)),
            .step     (step_n),
            .row_data (buf_n[elem_idx(r, 0, dim_p)*width_p +: LANE_W]),
            .elem_c   (lanes_c[r*width_p +: width_p]),
            .valid_c  (lane_valid_c[r])
        );
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r   <= IDLE;
            step_r    <= '0;
            buf_r     <= '0;
            valid_d_r <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            state_r   <= state_n;
            step_r    <= step_n;
            buf_r     <= buf_n;
            valid_d_r <= bus.valid_i;
            ready_r   <= ready_n;
        end
    end

`ifdef SKEW_FEEDER_PINGPONG_EN
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            shd_r      <= '0;
            shd_full_r <= 1'b0;
        end else begin
            shd_r      <= shd_n;
            shd_full_r <= shd_full_n;
        end
    end
`endif

    // Beat outputs; idle cycles present all-zero lanes.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_r      <= 1'b0;
            data_r       <= '0;
            lane_valid_r <= '0;
            last_r       <= 1'b0;
        end else begin
            valid_r      <= stream_n;
            data_r       <= stream_n ? lanes_c : '0;
            lane_valid_r <= stream_n ? lane_valid_c : '0;
            last_r       <= stream_n && (step_n == STEP_W'(LAST_STEP));
        end
    end

    assign bus.ready_o      = ready_r;
    assign bus.valid_o      = valid_r;
    assign bus.data_o       = data_r;
    assign bus.lane_valid_o = lane_valid_r;
    assign bus.last_o       = last_r;

endmodule

// File: tb/tb_skew_feeder.sv
// Scoreboard bench for skew_feeder: expected beats are queued at issue time, a monitor pops them.
module tb_skew_feeder;
    localparam int W = 8;
    localparam int D = 4;
    localparam int STEPS = 2 * D - 1;

    typedef struct {
        logic [W*D-1:0] data;
        logic [D-1:0]   lv;
        logic           last;
        int             k;
        bit             b2b;
    } beat_t;

    logic clk;
    logic reset_ni;
    skew_feeder_if #(.width_p(W), .dim_p(D)) bus ();

    skew_feeder #(.width_p(W), .dim_p(D)) dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    vectors;
    int    miscompares;
    bit    rand_rdy;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: lane r replays row r after r idle steps; everything else is an empty slot.
    task automatic push_matrix(input logic [W*D*D-1:0] m, input bit b2b);
        logic [W-1:0] lane[STEPS][D];
        bit           used[STEPS][D];
        beat_t        e;
        for (int k = 0; k < STEPS; k++)
            for (int r = 0; r < D; r++) begin
                lane[k][r] = '0;
                used[k][r] = 1'b0;
            end
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) begin
                lane[r+c][r] = m[(r*D+c)*W +: W];
                used[r+c][r] = 1'b1;
            end
        for (int k = 0; k < STEPS; k++) begin
            for (int r = 0; r < D; r++) begin
                e.data[r*W +: W] = lane[k][r];
                e.lv[r]          = used[k][r];
            end
            e.last = (k == STEPS - 1);
            e.k    = k;
            e.b2b  = b2b && (k == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic monitor();
        int          cyc;
        int          last_hs;
        bit          have_prev;
        logic        p_valid, p_ready, p_last;
        logic [D-1:0]   p_lv;
        logic [W*D-1:0] p_data;
        beat_t       e;
        cyc = 0; last_hs = 0; have_prev = 0;
        p_valid = 0; p_ready = 0; p_last = 0; p_lv = '0; p_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_ni) begin
                have_prev = 0;
            end else begin
                if (have_prev && p_valid && !p_ready)
                    chk("stall_hold", {bus.valid_o, bus.last_o, bus.lane_valid_o, bus.data_o},
                        {1'b1, p_last, p_lv, p_data});
`ifndef SKEW_FEEDER_PINGPONG_EN
                if (bus.valid_o) chk("ready_while_streaming", 128'(bus.ready_o), 128'(0));
`endif
                if (bus.valid_o && bus.ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 128'(exp_q.size()), 128'(1));
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("beat_data_k%0d", e.k), 128'(bus.data_o), 128'(e.data));
                        chk($sformatf("beat_lane_valid_k%0d", e.k), 128'(bus.lane_valid_o), 128'(e.lv));
                        chk($sformatf("beat_last_k%0d", e.k), 128'(bus.last_o), 128'(e.last));
                        if (e.b2b) chk("back_to_back_gap", 128'(cyc - last_hs), 128'(1));
                    end
                    last_hs = cyc;
                end
                have_prev = 1;
            end
            p_valid = bus.valid_o; p_ready = bus.ready_i; p_last = bus.last_o;
            p_lv = bus.lane_valid_o; p_data = bus.data_o;
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.ready_i = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Waits for ready_o, raises valid_i for 'hold' cycles, and queues the expected beats.
    task automatic send(input logic [W*D*D-1:0] m, input int hold, input bit b2b);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) ok = 1;
        end
        if (!ok) chk("ready_timeout", 128'(bus.ready_o), 128'(1));
        push_matrix(m, b2b);
        bus.data_i  = m;
        bus.valid_i = 1'b1;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        bus.valid_i = 1'b0;
    endtask

    // Returns at posedge+1 when beat k of the head matrix is on the outputs.
    task automatic wait_k(input int k);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid_o && exp_q.size() > 0 && exp_q[0].k == k) ok = 1;
        end
        if (!ok) chk($sformatf("wait_k%0d_timeout", k), 128'(0), 128'(1));
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.valid_o) ok = 1;
        end
        if (!ok) chk("drain_timeout", 128'(exp_q.size()), 128'(0));
        repeat (4) @(negedge clk);
        chk("idle_valid", 128'(bus.valid_o), 128'(0));
        chk("idle_ready", 128'(bus.ready_o), 128'(1));
    endtask

    function automatic logic [W*D*D-1:0] ref_matrix();
        logic [W*D*D-1:0] m;
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++)
                m[(r*D+c)*W +: W] = W'(r * 16 + c);
        return m;
    endfunction

    function automatic logic [W*D*D-1:0] rand_matrix();
        logic [W*D*D-1:0] m;
        for (int i = 0; i < W*D*D/32; i++) m[i*32 +: 32] = $urandom();
        return m;
    endfunction

    initial begin
        vectors = 0; miscompares = 0; rand_rdy = 0;
        reset_ni = 1'b0;
        bus.valid_i = 1'b0; bus.data_i = '0; bus.ready_i = 1'b1;
        fork
            monitor();
            ready_driver();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1);
            end
        join_none

        #12;
        chk("reset_valid", 128'(bus.valid_o), 128'(0));
        chk("reset_last", 128'(bus.last_o), 128'(0));
        chk("reset_lane_valid", 128'(bus.lane_valid_o), 128'(0));
        chk("reset_data", 128'(bus.data_o), 128'(0));
        @(posedge clk); #1 reset_ni = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 128'(bus.ready_o), 128'(1));

        // Single reference matrix with a free-running consumer.
        send(ref_matrix(), 1, 0);
        drain();

        // Level held for 20 cycles yields one matrix.
        send(ref_matrix(), 20, 0);
        drain();

        // Consumer stalls three cycles while beat 2 is presented.
        send(rand_matrix(), 1, 0);
        wait_k(2);
        bus.ready_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.ready_i = 1'b1;
        drain();

        // Asynchronous reset in the middle of the stream.
        send(rand_matrix(), 1, 0);
        wait_k(4);
        #1 reset_ni = 1'b0;
        exp_q.delete();
        #1;
        chk("midstream_reset_valid", 128'(bus.valid_o), 128'(0));
        chk("midstream_reset_lane_valid", 128'(bus.lane_valid_o), 128'(0));
        @(posedge clk); @(posedge clk); #1 reset_ni = 1'b1;
        @(negedge clk);
        chk("post_midstream_reset_ready", 128'(bus.ready_o), 128'(1));
        send(ref_matrix(), 1, 0);
        drain();

        // Second pulse arriving while the first matrix is at beat 2.
        send(ref_matrix(), 1, 0);
        wait_k(2);
`ifdef SKEW_FEEDER_PINGPONG_EN
        chk("pp_ready_before_second", 128'(bus.ready_o), 128'(1));
        push_matrix(~ref_matrix(), 1);
`else
        chk("busy_ready_before_second", 128'(bus.ready_o), 128'(0));
`endif
        bus.data_i  = ~ref_matrix();
        bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
`ifdef SKEW_FEEDER_PINGPONG_EN
        chk("pp_ready_after_shadow_load", 128'(bus.ready_o), 128'(0));
`endif
        drain();

        // Randomized matrices, hold lengths, gaps and consumer back-pressure.
        rand_rdy = 1;
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(rand_matrix(), $urandom_range(1, 4), 0);
        end
        rand_rdy = 0;
        @(posedge clk); #1 bus.ready_i = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
